// File: rtl/spk_pack_nn_pkg.sv
// Shared configuration, state codes and request record for the spike packer.
package spk_pack_nn_pkg;

  localparam int NUM_CH     = 160;
  localparam int WIDTH_CH   = 12;
  localparam int NN         = 4;
  localparam int PRE        = 7;
  localparam int POST       = 11;
  localparam int DEPTH      = 64;
  localparam int PEND_DEPTH = 16;

  // Window length in frames: PRE frames before the peak, the peak frame, POST after.
  function automatic int spk_len_f(input int pre, input int post);
    return pre + 1 + post;
  endfunction

  localparam int SPK_LEN   = spk_len_f(PRE, POST);
  localparam int SLOT_W    = $clog2(DEPTH);
  localparam int RAM_WORDS = DEPTH * NUM_CH;
  localparam int RAW       = $clog2(RAM_WORDS);
  localparam int NN_W      = $clog2(NN + 1);
  localparam int K_W       = $clog2(SPK_LEN);

  // Channel indices at or above this value are not stored and never read.
  localparam logic [WIDTH_CH-1:0] NUM_CH_GUARD = WIDTH_CH'(NUM_CH);

  // Packet FSM state codes.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  // One pending peak: channel, frame it occurred in, and its neighbour list.
  typedef struct packed {
    logic [WIDTH_CH-1:0] ch;
    logic [31:0]         frame;
    logic [NN*8-1:0]     group;
  } spk_req_t;

endpackage

// File: rtl/spk_pack_nn_if.sv
// Sample input stream and spike output stream of the spike packer.
//
// Output handshake: a beat transfers on a rising clk edge where spk_TVALID and
// spk_TREADY are both 1. Once spk_TVALID is raised, spk_TDATA/TCH/TTIME/TDEST/
// TLAST hold their values until that transfer; spk_TVALID never waits on
// spk_TREADY. The input stream has no backpressure: every valid_in cycle is taken.
interface spk_pack_nn_if;
  import spk_pack_nn_pkg::*;

  logic [31:0]         frame_No_in;
  logic [WIDTH_CH-1:0] ch_in;
  logic [NN*8-1:0]     ch_group_in;
  logic                valid_in;
  logic [31:0]         v_in;
  logic                is_peak_in;

  logic                spk_TVALID;
  logic                spk_TREADY;
  logic [NN*32-1:0]    spk_TDATA;
  logic [WIDTH_CH-1:0] spk_TCH;
  logic [31:0]         spk_TTIME;
  logic [15:0]         spk_TDEST;
  logic                spk_TLAST;

  modport master (
    output frame_No_in, ch_in, ch_group_in, valid_in, v_in, is_peak_in,
    output spk_TREADY,
    input  spk_TVALID, spk_TDATA, spk_TCH, spk_TTIME, spk_TDEST, spk_TLAST
  );

  modport slave (
    input  frame_No_in, ch_in, ch_group_in, valid_in, v_in, is_peak_in,
    input  spk_TREADY,
    output spk_TVALID, spk_TDATA, spk_TCH, spk_TTIME, spk_TDEST, spk_TLAST
  );

endinterface

// File: rtl/spk_pack_nn_req_fifo.sv
// Synchronous FIFO of pending peak requests. Full is judged on the state before
// any same-cycle pop, so a push into a full FIFO is refused even if it drains.
module spk_pack_nn_req_fifo
  import spk_pack_nn_pkg::*;
#(
  parameter int DEPTH_P = PEND_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  spk_req_t din,
  input  logic     pop,
  output spk_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH_P);

  spk_req_t      mem [DEPTH_P];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate every use.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update: push and pop are independent, each guarded by its own flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spk_pack_nn.sv
// Spike packer: stores every sample in a frame ring, queues detected peaks and,
// once POST later frames have arrived, streams one packet per peak holding the
// SPK_LEN-frame window of the peak's NN neighbour channels.
module spk_pack_nn
  import spk_pack_nn_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  spk_pack_nn_if.slave bus,
  output logic         spk_pulse,
  output logic [15:0]  drop_cnt,
  output logic [1:0]   dbg_state
);

  logic [1:0]      state;
  logic [K_W-1:0]  beat_k;
  logic [NN_W-1:0] fetch_n;

  spk_req_t        req;
  spk_req_t        push_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic            peak_ok;
  logic            push;
  logic            pop;
  logic            drop_push;
  logic            drop_stale;

  logic [31:0]     cur_f;
  logic [31:0]     age;
  logic            stale;
  logic            ripe;

  logic            send;
  logic            accept;
  logic            last_beat;

  logic [31:0]     ring [RAM_WORDS];
  logic            wr_en;
  logic [RAW-1:0]  waddr;
  logic [RAW-1:0]  raddr;
  logic [31:0]     rdata;
  logic [SLOT_W-1:0] rd_slot;
  logic [7:0]      nb_ch;
  logic            nb_ok;

  logic            rd_pend;
  logic            rd_zero;
  logic [NN_W-1:0] rd_lane;
  logic [31:0]     lane_q [NN];
  logic [NN*32-1:0] tdata;

  logic [1:0]      drop_inc;
  logic [16:0]     drop_sum;

  // ---------------- input side ----------------
  assign wr_en   = bus.valid_in && (bus.ch_in < NUM_CH_GUARD);
  assign peak_ok = wr_en && bus.is_peak_in;
  assign push    = peak_ok && !fifo_full;
  assign drop_push = peak_ok && fifo_full;

  assign push_req.ch    = bus.ch_in;
  assign push_req.frame = bus.frame_No_in;
  assign push_req.group = bus.ch_group_in;

  assign waddr = RAW'(bus.frame_No_in[SLOT_W-1:0]) * RAW'(NUM_CH) + RAW'(bus.ch_in);

  // Sample ring write: each in-range sample lands in its frame slot at once.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) ring[waddr] <= bus.v_in;
  end

  // Registered read port; a same-address write in the same cycle is not seen.
  always_ff @(posedge clk) begin
    rdata <= ring[raddr];
  end

  // Track the most recent frame number seen on the input.
  always_ff @(posedge clk) begin
    if (rst) cur_f <= '0;
    else if (bus.valid_in) cur_f <= bus.frame_No_in;
  end

  spk_pack_nn_req_fifo #(.DEPTH_P(PEND_DEPTH)) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .dout  (req),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- window bookkeeping ----------------
  // Age of the head peak in frames; the compare is widened so it cannot wrap.
  assign age   = cur_f - req.frame;
  assign stale = ({1'b0, age} + 33'(PRE)) >= 33'(DEPTH - SPK_LEN);
  assign ripe  = age > 32'(POST);

  assign send      = (state == ST_SEND);
  assign accept    = send && bus.spk_TREADY;
  assign last_beat = (beat_k == K_W'(SPK_LEN - 1));
  assign drop_stale = (state == ST_CHECK) && stale;
  assign pop       = drop_stale || (accept && last_beat);

  // Neighbour channel for the read issued this cycle.
  always_comb begin
    nb_ch = '0;
    for (int i = 0; i < NN; i++) begin
      if (NN_W'(i) == fetch_n) nb_ch = req.group[i*8 +: 8];
    end
  end

  assign nb_ok   = (WIDTH_CH'(nb_ch) < NUM_CH_GUARD);
  assign rd_slot = req.frame[SLOT_W-1:0] - SLOT_W'(PRE) + SLOT_W'(beat_k);
  assign raddr   = RAW'(rd_slot) * RAW'(NUM_CH) + (nb_ok ? RAW'(nb_ch) : '0);

  // ---------------- packet FSM ----------------
  // IDLE waits for a peak, CHECK waits for its window, FETCH reads NN lanes,
  // SEND holds one beat until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      beat_k  <= '0;
      fetch_n <= '0;
      rd_pend <= 1'b0;
      rd_zero <= 1'b0;
      rd_lane <= '0;
    end else begin
      rd_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (stale) begin
            state <= ST_IDLE;
          end else if (ripe) begin
            state   <= ST_FETCH;
            beat_k  <= '0;
            fetch_n <= '0;
          end
        end
        ST_FETCH: begin
          if (fetch_n != NN_W'(NN)) begin
            rd_pend <= 1'b1;
            rd_lane <= fetch_n;
            rd_zero <= !nb_ok;
            fetch_n <= fetch_n + 1'b1;
          end else begin
            state <= ST_SEND;
          end
        end
        default: begin
          if (bus.spk_TREADY) begin
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              beat_k  <= beat_k + 1'b1;
              fetch_n <= '0;
              state   <= ST_FETCH;
            end
          end
        end
      endcase
    end
  end

  // Capture read data into its lane one cycle after the read was issued.
  always_ff @(posedge clk) begin
    if (rd_pend) begin
      for (int i = 0; i < NN; i++) begin
        if (NN_W'(i) == rd_lane) lane_q[i] <= rd_zero ? 32'd0 : rdata;
      end
    end
  end

  // Lane 0 goes to the most significant word; outputs read 0 whenever idle.
  always_comb begin
    tdata = '0;
    if (send) begin
      for (int i = 0; i < NN; i++) tdata[(NN-1-i)*32 +: 32] = lane_q[i];
    end
  end

  assign bus.spk_TVALID = send;
  assign bus.spk_TDATA  = tdata;
  assign bus.spk_TCH    = send ? req.ch : '0;
  assign bus.spk_TTIME  = send ? req.frame : '0;
  assign bus.spk_TDEST  = send ? 16'(beat_k) : 16'd0;
  assign bus.spk_TLAST  = send && last_beat;
  assign spk_pulse      = accept && (beat_k == '0);
  assign dbg_state      = state;

  // ---------------- drop counter ----------------
  assign drop_inc = {1'b0, drop_push} + {1'b0, drop_stale};
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

  // Saturating count of peaks refused by a full queue or expired before sending.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (drop_inc != 2'd0) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

endmodule

// File: tb/tb_spk_pack_nn.sv
// Directed bench for spk_pack_nn: ramp samples v = frame*1000 + ch, peaks with
// hand-computed windows, checked beat by beat against an expected queue.
module tb_spk_pack_nn;
  import spk_pack_nn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spk_pack_nn_if bus ();
  logic        spk_pulse;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;

  spk_pack_nn dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .spk_pulse (spk_pulse),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  localparam logic [31:0] GRP = 32'hFF06_0504;  // neighbours {4,5,6,pad}

  typedef struct {
    logic [127:0] d;
    logic [11:0]  ch;
    logic [31:0]  t;
    logic [15:0]  dest;
    logic         last;
  } beat_t;

  int total = 0;
  int bad   = 0;
  beat_t beats[$];
  logic [127:0] exp_q[$];
  int pulses = 0;
  int stall_cycles = 0;
  int ready_mode = 0;
  int rcyc = 0;
  beat_t prev;
  beat_t cur;
  logic prev_stall = 1'b0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat monitor and hold-while-stalled check.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cur.d    = bus.spk_TDATA;
      cur.ch   = bus.spk_TCH;
      cur.t    = bus.spk_TTIME;
      cur.dest = bus.spk_TDEST;
      cur.last = bus.spk_TLAST;
      if (prev_stall) begin
        chk("hold_valid", 128'(bus.spk_TVALID), 128'd1);
        chk("hold_data", cur.d, prev.d);
        chk("hold_ctrl", 128'({cur.ch, cur.t, cur.dest, cur.last}),
            128'({prev.ch, prev.t, prev.dest, prev.last}));
      end
      if (bus.spk_TVALID && bus.spk_TREADY) beats.push_back(cur);
      if (bus.spk_TVALID && !bus.spk_TREADY) stall_cycles++;
      if (spk_pulse) pulses++;
      prev_stall = bus.spk_TVALID && !bus.spk_TREADY;
      prev = cur;
    end
  end

  // Downstream ready: 0 = always ready, 1 = ready one cycle in three, 2 = stalled.
  initial begin
    bus.spk_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (ready_mode)
        0:       bus.spk_TREADY = 1'b1;
        1:       bus.spk_TREADY = (rcyc % 3 == 0);
        default: bus.spk_TREADY = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.is_peak_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic put_sample(input logic [31:0] f, input logic [11:0] ch, input logic pk,
                            input logic [31:0] grp);
    bus.frame_No_in = f;
    bus.ch_in       = ch;
    bus.v_in        = f * 32'd1000 + 32'(ch);
    bus.is_peak_in  = pk;
    bus.ch_group_in = grp;
    bus.valid_in    = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in   = 1'b0;
    bus.is_peak_in = 1'b0;
  endtask

  task automatic put_frame(input logic [31:0] f, input int nch, input int pk_ch,
                           input logic [31:0] grp);
    for (int c = 0; c < nch; c++) put_sample(f, 12'(c), (c == pk_ch), grp);
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (beats.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 128'(beats.size() >= n), 128'd1);
  endtask

  // Expected lanes for a peak at pf with neighbours {4,5,6,pad}.
  task automatic exp_window(input logic [31:0] pf);
    logic [31:0] f;
    logic [31:0] v;
    exp_q.delete();
    for (int k = 0; k < 19; k++) begin
      f = pf - 32'd7 + 32'(k);
      v = f * 32'd1000;
      exp_q.push_back({v + 32'd4, v + 32'd5, v + 32'd6, 32'd0});
    end
  endtask

  task automatic check_packet(input string tag, input logic [31:0] pf, input logic [11:0] pch);
    chk({tag, "_beats"}, 128'(beats.size()), 128'd19);
    for (int k = 0; k < 19 && k < beats.size(); k++) begin
      chk($sformatf("%s_tdata_b%0d", tag, k), beats[k].d, exp_q.pop_front());
      chk($sformatf("%s_tdest_b%0d", tag, k), 128'(beats[k].dest), 128'(k));
      chk($sformatf("%s_tlast_b%0d", tag, k), 128'(beats[k].last), 128'(k == 18));
      chk($sformatf("%s_ttime_b%0d", tag, k), 128'(beats[k].t), 128'(pf));
      chk($sformatf("%s_tch_b%0d", tag, k), 128'(beats[k].ch), 128'(pch));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.frame_No_in = '0;
    bus.ch_in = '0;
    bus.ch_group_in = '0;
    bus.valid_in = 1'b0;
    bus.v_in = '0;
    bus.is_peak_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_tvalid", 128'(bus.spk_TVALID), 128'd0);
    chk("rst_tlast", 128'(bus.spk_TLAST), 128'd0);
    chk("rst_tdata", bus.spk_TDATA, 128'd0);
    chk("rst_tdest", 128'(bus.spk_TDEST), 128'd0);
    chk("rst_pulse", 128'(spk_pulse), 128'd0);
    chk("rst_drop", 128'(drop_cnt), 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);

    // 1: single peak, always ready
    ready_mode = 0;
    beats.delete();
    pulses = 0;
    for (int i = 0; i < 23; i++) put_frame(32'd90 + 32'(i), 8, (i == 10) ? 5 : -1, GRP);
    exp_window(32'd100);
    chk("t1_b0_hand", exp_q[0], {32'd93004, 32'd93005, 32'd93006, 32'd0});
    chk("t1_b18_hand", exp_q[18], {32'd111004, 32'd111005, 32'd111006, 32'd0});
    wait_beats(19, 400, "t1_timeout");
    repeat (30) @(negedge clk);
    check_packet("t1", 32'd100, 12'd5);
    chk("t1_pulses", 128'(pulses), 128'd1);
    chk("t1_drop", 128'(drop_cnt), 128'd0);

    // 2: same peak, ready one cycle in three
    ready_mode = 1;
    beats.delete();
    pulses = 0;
    stall_cycles = 0;
    for (int i = 0; i < 23; i++) put_frame(32'd90 + 32'(i), 8, (i == 10) ? 5 : -1, GRP);
    exp_window(32'd100);
    wait_beats(19, 1000, "t2_timeout");
    repeat (30) @(negedge clk);
    check_packet("t2", 32'd100, 12'd5);
    chk("t2_pulses", 128'(pulses), 128'd1);
    chk("t2_stalled", 128'(stall_cycles > 0), 128'd1);

    // 3: 20 peaks in one frame with downstream stalled
    do_reset();
    ready_mode = 2;
    beats.delete();
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 20; c++)
        put_sample(32'd193 + 32'(i), 12'(c), (i == 7), {24'hFFFFFF, 8'(c)});
    end
    @(negedge clk);
    chk("t3_drop_full", 128'(drop_cnt), 128'd4);
    chk("t3_no_beats", 128'(beats.size()), 128'd0);
    ready_mode = 0;
    wait_beats(304, 3000, "t3_timeout");
    repeat (40) @(negedge clk);
    chk("t3_beats", 128'(beats.size()), 128'd304);
    for (int p = 0; p < 16 && (p * 19 + 18) < beats.size(); p++) begin
      chk($sformatf("t3_tch_p%0d", p), 128'(beats[p*19].ch), 128'(p));
      chk($sformatf("t3_ttime_p%0d", p), 128'(beats[p*19].t), 128'd200);
      chk($sformatf("t3_lane0_p%0d", p), beats[p*19].d, {32'(193000 + p), 96'd0});
      chk($sformatf("t3_tlast_p%0d", p), 128'(beats[p*19+18].last), 128'd1);
    end
    chk("t3_drop_end", 128'(drop_cnt), 128'd4);

    // 4: window across the 32-bit frame wrap
    do_reset();
    ready_mode = 0;
    beats.delete();
    pulses = 0;
    for (int i = 0; i < 22; i++)
      put_frame(32'hFFFF_FFEF + 32'(i), 8, (i == 9) ? 5 : -1, GRP);
    exp_window(32'hFFFF_FFF8);
    wait_beats(19, 400, "t4_timeout");
    repeat (30) @(negedge clk);
    check_packet("t4", 32'hFFFF_FFF8, 12'd5);
    chk("t4_pulses", 128'(pulses), 128'd1);

    // 5: long stall makes the queued second peak stale
    do_reset();
    ready_mode = 2;
    beats.delete();
    for (int i = 0; i < 100; i++)
      put_frame(32'd293 + 32'(i), 8, (i == 7) ? 5 : ((i == 8) ? 6 : -1), GRP);
    @(negedge clk);
    chk("t5_drop_held", 128'(drop_cnt), 128'd0);
    ready_mode = 0;
    wait_beats(19, 400, "t5_timeout");
    repeat (40) @(negedge clk);
    chk("t5_beats", 128'(beats.size()), 128'd19);
    chk("t5_tch", 128'(beats[0].ch), 128'd5);
    chk("t5_ttime", 128'(beats[0].t), 128'd300);
    chk("t5_tlast", 128'(beats[18].last), 128'd1);
    chk("t5_drop", 128'(drop_cnt), 128'd1);
    chk("t5_state", 128'(dbg_state), 128'd0);

    // 6: reset during beat 7, then a fresh packet
    do_reset();
    ready_mode = 0;
    beats.delete();
    for (int i = 0; i < 23; i++)
      put_frame(32'd90 + 32'(i), 8, (i == 10) ? 5 : ((i == 11) ? 6 : -1), GRP);
    wait_beats(7, 400, "t6_timeout");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_tvalid", 128'(bus.spk_TVALID), 128'd0);
    chk("t6_drop", 128'(drop_cnt), 128'd0);
    repeat (5) @(negedge clk);
    chk("t6_idle", 128'(dbg_state), 128'd0);
    chk("t6_beats", 128'(beats.size()), 128'd7);
    chk("t6_no_last", 128'(beats[6].last), 128'd0);
    beats.delete();
    pulses = 0;
    for (int i = 0; i < 23; i++) put_frame(32'd90 + 32'(i), 8, (i == 10) ? 5 : -1, GRP);
    exp_window(32'd100);
    wait_beats(19, 400, "t6b_timeout");
    repeat (30) @(negedge clk);
    check_packet("t6b", 32'd100, 12'd5);
    chk("t6b_pulses", 128'(pulses), 128'd1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
